// File: rtl/eriscv_rst_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// eriscv_rst_ctrl_pkg
//   Shared constants for the eriscv board-side reset sequencer:
//   - rst_ctrl_state_e : sequencer state codes (SYNC/HOLD/RUN/SOFT)
//   - RST_CAUSE_*      : encodings reported on rst_cause
//   - max_int          : elaboration-time helper for counter sizing
// ---------------------------------------------------------------------------
package eriscv_rst_ctrl_pkg;

   typedef enum logic [1:0] {
      RST_CTRL_SYNC = 2'd0,
      RST_CTRL_HOLD = 2'd1,
      RST_CTRL_RUN  = 2'd2,
      RST_CTRL_SOFT = 2'd3
   } rst_ctrl_state_e;

   localparam logic [1:0] RST_CAUSE_POR  = 2'b00;
   localparam logic [1:0] RST_CAUSE_SOFT = 2'b01;
   localparam logic [1:0] RST_CAUSE_WDT  = 2'b10;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/eriscv_rst_sync.sv
// ---------------------------------------------------------------------------
// eriscv_rst_sync
//   Reset-deassertion synchroniser. The chain is cleared asynchronously while
//   rst is low and shifts in ones after release, so sync_out rises on the
//   SYNC_STAGES-th clock edge after rst goes high.
// Ports:
//   clk      in  system clock
//   rst      in  raw reset, asynchronous, active-low
//   sync_out out synchronised "reset released" level
// ---------------------------------------------------------------------------
module eriscv_rst_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   output logic sync_out
);

   logic [SYNC_STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chain <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign sync_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/eriscv_rst_ctrl.sv
// ---------------------------------------------------------------------------
// eriscv_rst_ctrl
//   Board-side reset sequencer for eriscv_min_sopc. Synchronises release of
//   the raw reset, stretches it by HOLD_CYCLES, then drives the active-high
//   core reset low. Also services a soft-reset request and, when the macro
//   ERISCV_WDT_EN is defined, a watchdog that forces a core reset.
// Ports:
//   clk           in  system clock
//   rst           in  raw reset, asynchronous, active-low
//   soft_rst_req  in  soft-reset request (level)
//   soft_rst_ack  out soft-reset acknowledge
//   wdt_kick      in  watchdog restart strobe (unused without ERISCV_WDT_EN)
//   core_rst      out core reset, 1 = asserted
//   rst_done      out one-cycle pulse on the cycle core_rst deasserts
//   rst_cause     out last reset cause: 00 power-on, 01 soft, 10 watchdog
// Handshake: soft_rst_req/soft_rst_ack are four-phase. req rises and is
//   held; ack rises on the edge that samples req high in RUN; ack stays high
//   until req is sampled low and falls on that edge; the core is released
//   only after the soft hold count is done with both req and ack low.
// Debug: the FSM state is held in 'state' (rst_ctrl_state_e).
// ---------------------------------------------------------------------------
module eriscv_rst_ctrl
   import eriscv_rst_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 16,
   parameter int SOFT_CYCLES = 8,
   parameter int WDT_CYCLES  = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       soft_rst_req,
   output logic       soft_rst_ack,
   input  logic       wdt_kick,
   output logic       core_rst,
   output logic       rst_done,
   output logic [1:0] rst_cause
);

   localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, SOFT_CYCLES) + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_CYCLES - 1);

   rst_ctrl_state_e  state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             core_rst_d, ack_d, done_d;
   logic [1:0]       cause_d;
   logic             sync_out;
   logic             wdt_expire;

   eriscv_rst_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .rst      (rst),
      .sync_out (sync_out)
   );

`ifdef ERISCV_WDT_EN
   localparam int WDT_W = $clog2(WDT_CYCLES + 1);
   localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

   logic [WDT_W-1:0] wdt_cnt;

   // Held at zero outside RUN, so every entry to RUN starts a fresh timeout.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdt_cnt <= '0;
      end else if ((state != RST_CTRL_RUN) || wdt_kick) begin
         wdt_cnt <= '0;
      end else if (wdt_cnt != WDT_LAST) begin
         wdt_cnt <= wdt_cnt + WDT_W'(1);
      end
   end

   // A kick on the expiry cycle wins over the timeout.
   assign wdt_expire = (state == RST_CTRL_RUN) && (wdt_cnt == WDT_LAST) && !wdt_kick;
`else
   logic unused_wdt;
   assign unused_wdt = wdt_kick ^ (WDT_CYCLES == 0);
   assign wdt_expire = 1'b0;
`endif

   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      core_rst_d = core_rst;
      ack_d      = soft_rst_ack;
      done_d     = 1'b0;
      cause_d    = rst_cause;
      case (state)
         RST_CTRL_SYNC: begin
            core_rst_d = 1'b1;
            if (sync_out) begin
               state_d = RST_CTRL_HOLD;
               cnt_d   = '0;
            end
         end
         RST_CTRL_HOLD: begin
            if (cnt == HOLD_LAST) begin
               state_d    = RST_CTRL_RUN;
               core_rst_d = 1'b0;
               done_d     = 1'b1;
               cnt_d      = '0;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         RST_CTRL_RUN: begin
            // Soft request has priority over a simultaneous watchdog expiry.
            if (soft_rst_req) begin
               state_d    = RST_CTRL_SOFT;
               core_rst_d = 1'b1;
               ack_d      = 1'b1;
               cause_d    = RST_CAUSE_SOFT;
               cnt_d      = '0;
            end else if (wdt_expire) begin
               state_d    = RST_CTRL_SOFT;
               core_rst_d = 1'b1;
               cause_d    = RST_CAUSE_WDT;
               cnt_d      = '0;
            end
         end
         RST_CTRL_SOFT: begin
            // ack can only fall here; a watchdog entry never raises it.
            ack_d = soft_rst_ack & soft_rst_req;
            if (cnt != SOFT_LAST) begin
               cnt_d = cnt + CNT_W'(1);
            end else if (!soft_rst_ack &&
                         ((rst_cause == RST_CAUSE_WDT) || !soft_rst_req)) begin
               state_d    = RST_CTRL_RUN;
               core_rst_d = 1'b0;
               done_d     = 1'b1;
               cnt_d      = '0;
            end
         end
         default: begin
            state_d = RST_CTRL_SYNC;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= RST_CTRL_SYNC;
         cnt          <= '0;
         core_rst     <= 1'b1;
         soft_rst_ack <= 1'b0;
         rst_done     <= 1'b0;
         rst_cause    <= RST_CAUSE_POR;
      end else begin
         state        <= state_d;
         cnt          <= cnt_d;
         core_rst     <= core_rst_d;
         soft_rst_ack <= ack_d;
         rst_done     <= done_d;
         rst_cause    <= cause_d;
      end
   end

endmodule
